// File: rtl/pipe_pkg.sv
// Shared Y86-64 pipeline definitions: instruction codes, register IDs and
// the E-stage register layout. Later stage registers (M, W) reuse this.
package pipe_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] RRSP  = 4'h4;
    localparam logic [3:0] RNONE = 4'hF;

    typedef struct packed {
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [63:0] valA;
        logic [63:0] valB;
        logic [63:0] valC;
        logic [3:0]  dstE;
        logic [3:0]  dstM;
        logic [3:0]  srcA;
        logic [3:0]  srcB;
    } ereg_t;

    // A bubble and the reset state are the same: a NOP that writes nothing.
    localparam ereg_t E_BUBBLE = '{
        icode: I_NOP, ifun: 4'h0,
        valA: 64'd0, valB: 64'd0, valC: 64'd0,
        dstE: RNONE, dstM: RNONE, srcA: RNONE, srcB: RNONE
    };

endpackage

// File: rtl/pipe_hazard_ctl.sv
// Combinational hazard detection for the D/E boundary: load/use,
// mispredicted jump and ret in flight, plus the resulting stall/bubble lines.
module pipe_hazard_ctl
    import pipe_pkg::*;
(
    input  logic [3:0] d_icode,
    input  logic [3:0] d_srcA,
    input  logic [3:0] d_srcB,
    input  logic [3:0] E_icode,
    input  logic [3:0] E_dstM,
    input  logic [3:0] M_icode,
    input  logic       e_Cnd,
    output logic       load_use,
    output logic       mispredict,
    output logic       ret_inflight,
    output logic       F_stall,
    output logic       D_stall,
    output logic       D_bubble,
    output logic       E_bubble
);

    logic e_is_load;

    // Hazard conditions and the controls derived from them; stall beats bubble in D.
    always_comb begin
        e_is_load    = (E_icode == I_MRMOVQ) || (E_icode == I_POPQ);
        // RNONE in E_dstM must never match, even against an RNONE source.
        load_use     = e_is_load && (E_dstM != RNONE) &&
                       ((E_dstM == d_srcA) || (E_dstM == d_srcB));
        mispredict   = (E_icode == I_JXX) && !e_Cnd;
        ret_inflight = (d_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
        F_stall      = load_use || ret_inflight;
        D_stall      = load_use;
        D_bubble     = mispredict || (ret_inflight && !load_use);
        E_bubble     = mispredict || load_use;
    end

endmodule

// File: rtl/execute_reg.sv
// Decode-to-execute pipeline register with integrated hazard control and
// saturating load/use and mispredict event counters.
module execute_reg
    import pipe_pkg::*;
#(
    parameter int CNT_W = 16
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       d_icode,
    input  logic [3:0]       d_ifun,
    input  logic [63:0]      d_valA,
    input  logic [63:0]      d_valB,
    input  logic [63:0]      d_valC,
    input  logic [3:0]       d_dstE,
    input  logic [3:0]       d_dstM,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic [3:0]       M_icode,
    input  logic             e_Cnd,
    output logic [3:0]       E_icode,
    output logic [3:0]       E_ifun,
    output logic [63:0]      E_valA,
    output logic [63:0]      E_valB,
    output logic [63:0]      E_valC,
    output logic [3:0]       E_dstE,
    output logic [3:0]       E_dstM,
    output logic [3:0]       E_srcA,
    output logic [3:0]       E_srcB,
    output logic             F_stall,
    output logic             D_stall,
    output logic             D_bubble,
    output logic [CNT_W-1:0] lu_cnt,
    output logic [CNT_W-1:0] mp_cnt
);

    ereg_t e_q;
    ereg_t e_in;
    logic  load_use;
    logic  mispredict;
    logic  ret_inflight;
    logic  E_bubble;
    logic  unused_ret;

    pipe_hazard_ctl u_hazard (
        .d_icode     (d_icode),
        .d_srcA      (d_srcA),
        .d_srcB      (d_srcB),
        .E_icode     (e_q.icode),
        .E_dstM      (e_q.dstM),
        .M_icode     (M_icode),
        .e_Cnd       (e_Cnd),
        .load_use    (load_use),
        .mispredict  (mispredict),
        .ret_inflight(ret_inflight),
        .F_stall     (F_stall),
        .D_stall     (D_stall),
        .D_bubble    (D_bubble),
        .E_bubble    (E_bubble)
    );

    // ret_inflight only feeds the controls inside the hazard block.
    assign unused_ret = ret_inflight;

    assign e_in = '{
        icode: d_icode, ifun: d_ifun,
        valA: d_valA, valB: d_valB, valC: d_valC,
        dstE: d_dstE, dstM: d_dstM, srcA: d_srcA, srcB: d_srcB
    };

    // E register: reset, then bubble, then normal capture of decode outputs.
    always_ff @(posedge clk) begin
        if (rst || E_bubble) e_q <= E_BUBBLE;
        else                 e_q <= e_in;
    end

    // Saturating hazard event counters; a hazard on the reset edge is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            lu_cnt <= '0;
            mp_cnt <= '0;
        end else begin
            if (load_use && (lu_cnt != '1))   lu_cnt <= lu_cnt + CNT_W'(1);
            if (mispredict && (mp_cnt != '1)) mp_cnt <= mp_cnt + CNT_W'(1);
        end
    end

    assign E_icode = e_q.icode;
    assign E_ifun  = e_q.ifun;
    assign E_valA  = e_q.valA;
    assign E_valB  = e_q.valB;
    assign E_valC  = e_q.valC;
    assign E_dstE  = e_q.dstE;
    assign E_dstM  = e_q.dstM;
    assign E_srcA  = e_q.srcA;
    assign E_srcB  = e_q.srcB;

endmodule

// File: tb/tb_execute_reg.sv
// Self-checking bench for execute_reg: directed scenarios plus randomized
// cycles checked against a behavioural model of the E stage and counters.
module tb_execute_reg;

    localparam int CNT_W = 4;
    localparam int SAT   = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [63:0] valA;
        logic [63:0] valB;
        logic [63:0] valC;
        logic [3:0]  dstE;
        logic [3:0]  dstM;
        logic [3:0]  srcA;
        logic [3:0]  srcB;
    } mreg_t;

    localparam mreg_t NOPREG = {4'h1, 4'h0, 192'd0, 16'hFFFF};

    logic clk = 1'b0;
    logic rst;
    logic [3:0] d_icode, d_ifun, d_dstE, d_dstM, d_srcA, d_srcB, M_icode;
    logic [63:0] d_valA, d_valB, d_valC;
    logic e_Cnd;
    logic [3:0] E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB;
    logic [63:0] E_valA, E_valB, E_valC;
    logic F_stall, D_stall, D_bubble;
    logic [CNT_W-1:0] lu_cnt, mp_cnt;
    mreg_t dut_e;

    mreg_t m;
    int m_lu, m_mp;
    int errors = 0;
    int checks = 0;

    execute_reg #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .d_icode(d_icode), .d_ifun(d_ifun),
        .d_valA(d_valA), .d_valB(d_valB), .d_valC(d_valC),
        .d_dstE(d_dstE), .d_dstM(d_dstM), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .M_icode(M_icode), .e_Cnd(e_Cnd),
        .E_icode(E_icode), .E_ifun(E_ifun),
        .E_valA(E_valA), .E_valB(E_valB), .E_valC(E_valC),
        .E_dstE(E_dstE), .E_dstM(E_dstM), .E_srcA(E_srcA), .E_srcB(E_srcB),
        .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
        .lu_cnt(lu_cnt), .mp_cnt(mp_cnt)
    );

    always #5 clk = ~clk;

    assign dut_e = {E_icode, E_ifun, E_valA, E_valB, E_valC, E_dstE, E_dstM, E_srcA, E_srcB};

    // Reference rules, evaluated on the model's E contents and current inputs.
    function automatic bit mdl_lu();
        return ((m.icode == 4'h5) || (m.icode == 4'hB)) && (m.dstM != 4'hF) &&
               ((m.dstM == d_srcA) || (m.dstM == d_srcB));
    endfunction
    function automatic bit mdl_mp();
        return (m.icode == 4'h7) && !e_Cnd;
    endfunction
    function automatic bit mdl_ret();
        return (d_icode == 4'h9) || (m.icode == 4'h9) || (M_icode == 4'h9);
    endfunction
    function automatic logic [2:0] mdl_ctl();
        bit lu = mdl_lu();
        bit rt = mdl_ret();
        return {lu || rt, lu, mdl_mp() || (rt && !lu)};
    endfunction

    // Advance one clock and the model alongside it; returns 1 ns after the edge.
    task automatic tick();
        bit lu, mp, r;
        mreg_t nxt;
        lu  = mdl_lu();
        mp  = mdl_mp();
        r   = rst;
        nxt = {d_icode, d_ifun, d_valA, d_valB, d_valC, d_dstE, d_dstM, d_srcA, d_srcB};
        @(posedge clk);
        if (r) begin
            m = NOPREG; m_lu = 0; m_mp = 0;
        end else begin
            m = (lu || mp) ? NOPREG : nxt;
            if (lu && m_lu < SAT) m_lu++;
            if (mp && m_mp < SAT) m_mp++;
        end
        #1;
    endtask

    task automatic set_d(input logic [3:0] ic, input logic [3:0] dm, input logic [3:0] sa,
                         input logic [3:0] sb);
        d_icode = ic; d_ifun = 4'h0; d_dstE = 4'hF; d_dstM = dm; d_srcA = sa; d_srcB = sb;
        d_valA = {$urandom, $urandom}; d_valB = {$urandom, $urandom}; d_valC = {$urandom, $urandom};
    endtask

    task automatic test_reset();
        rst = 1'b1; M_icode = 4'h1; e_Cnd = 1'b0;
        set_d(4'h6, 4'h3, 4'h2, 4'h5);
        tick();
        set_d(4'h5, 4'h2, 4'h2, 4'h2);
        tick();
        rst = 1'b0;
        set_d(4'h6, 4'hF, 4'h2, 4'h3);
        #1;
        checks++;
        if (dut_e !== NOPREG) begin
            errors++; $display("FAIL reset_ereg got %h exp %h", dut_e, NOPREG);
        end
        checks++;
        if ({lu_cnt, mp_cnt} !== '0) begin
            errors++; $display("FAIL reset_cnt got lu=%0d mp=%0d exp 0 0", lu_cnt, mp_cnt);
        end
        checks++;
        if ({F_stall, D_stall, D_bubble} !== 3'b000) begin
            errors++; $display("FAIL reset_ctl got %b exp 000", {F_stall, D_stall, D_bubble});
        end
    endtask

    task automatic test_passthrough();
        d_icode = 4'h6; d_ifun = 4'h0; d_valA = 64'd5; d_valB = 64'd7; d_valC = 64'd0;
        d_dstE = 4'h3; d_dstM = 4'hF; d_srcA = 4'h2; d_srcB = 4'h3;
        #1;
        checks++;
        if ({F_stall, D_stall, D_bubble} !== 3'b000) begin
            errors++; $display("FAIL pass_ctl got %b exp 000", {F_stall, D_stall, D_bubble});
        end
        tick();
        checks++;
        if (dut_e !== {4'h6, 4'h0, 64'd5, 64'd7, 64'd0, 4'h3, 4'hF, 4'h2, 4'h3}) begin
            errors++; $display("FAIL pass_ereg got %h", dut_e);
        end
    endtask

    task automatic test_load_use();
        set_d(4'h5, 4'h3, 4'hF, 4'h1);
        tick();
        set_d(4'h6, 4'hF, 4'h2, 4'h3);
        #1;
        checks++;
        if ({F_stall, D_stall, D_bubble} !== 3'b110) begin
            errors++; $display("FAIL lu_ctl got %b exp 110", {F_stall, D_stall, D_bubble});
        end
        tick();
        checks++;
        if (dut_e !== NOPREG || lu_cnt !== CNT_W'(1)) begin
            errors++; $display("FAIL lu_bubble got icode=%h dstM=%h lu=%0d exp icode=1 dstM=f lu=1",
                               E_icode, E_dstM, lu_cnt);
        end
        checks++;
        if ({F_stall, D_stall, D_bubble} !== 3'b000) begin
            errors++; $display("FAIL lu_release got %b exp 000", {F_stall, D_stall, D_bubble});
        end
        tick();
        checks++;
        if (E_icode !== 4'h6 || E_srcB !== 4'h3 || E_valA !== d_valA) begin
            errors++; $display("FAIL lu_advance got icode=%h srcB=%h exp icode=6 srcB=3", E_icode, E_srcB);
        end
    endtask

    task automatic test_rnone();
        set_d(4'h5, 4'hF, 4'h1, 4'h1);
        tick();
        set_d(4'h6, 4'hF, 4'hF, 4'hF);
        #1;
        checks++;
        if (D_stall !== 1'b0 || F_stall !== 1'b0) begin
            errors++; $display("FAIL rnone_stall got F=%b D=%b exp 0 0", F_stall, D_stall);
        end
        tick();
    endtask

    task automatic test_mispredict();
        int mp0 = m_mp;
        set_d(4'h7, 4'hF, 4'hF, 4'hF);
        tick();
        e_Cnd = 1'b0;
        set_d(4'h6, 4'hF, 4'h1, 4'h2);
        #1;
        checks++;
        if ({F_stall, D_stall, D_bubble} !== 3'b001) begin
            errors++; $display("FAIL mp_ctl got %b exp 001", {F_stall, D_stall, D_bubble});
        end
        tick();
        checks++;
        if (E_icode !== 4'h1 || int'(mp_cnt) !== mp0 + 1) begin
            errors++; $display("FAIL mp_bubble got icode=%h mp=%0d exp icode=1 mp=%0d", E_icode, mp_cnt, mp0 + 1);
        end
        set_d(4'h7, 4'hF, 4'hF, 4'hF);
        tick();
        e_Cnd = 1'b1;
        set_d(4'h6, 4'hF, 4'h1, 4'h2);
        #1;
        checks++;
        if (D_bubble !== 1'b0) begin
            errors++; $display("FAIL taken_ctl got D_bubble=%b exp 0", D_bubble);
        end
        tick();
        checks++;
        if (E_icode !== 4'h6 || int'(mp_cnt) !== mp0 + 1) begin
            errors++; $display("FAIL taken_e got icode=%h mp=%0d exp icode=6 mp=%0d", E_icode, mp_cnt, mp0 + 1);
        end
        e_Cnd = 1'b0;
    endtask

    task automatic test_ret();
        set_d(4'h9, 4'hF, 4'h4, 4'h4);
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (F_stall !== 1'b1 || D_bubble !== 1'b1 || D_stall !== 1'b0) begin
                errors++; $display("FAIL ret_ctl cycle %0d got F=%b D=%b Db=%b exp 1 0 1",
                                   c, F_stall, D_stall, D_bubble);
            end
            tick();
            set_d(4'h1, 4'hF, 4'hF, 4'hF);
            M_icode = (c == 1) ? 4'h9 : 4'h1;
        end
        // ret in D while a load into %rsp sits in E
        set_d(4'h5, 4'h4, 4'hF, 4'hF);
        tick();
        set_d(4'h9, 4'hF, 4'h4, 4'h4);
        #1;
        checks++;
        if ({F_stall, D_stall, D_bubble} !== 3'b110) begin
            errors++; $display("FAIL ret_lu_ctl got %b exp 110", {F_stall, D_stall, D_bubble});
        end
        tick();
        set_d(4'h1, 4'hF, 4'hF, 4'hF);
        tick();
    endtask

    task automatic test_reset_mid_hazard();
        set_d(4'hB, 4'h2, 4'hF, 4'hF);
        tick();
        set_d(4'h6, 4'hF, 4'h2, 4'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (dut_e !== NOPREG || lu_cnt !== '0 || mp_cnt !== '0) begin
            errors++; $display("FAIL rst_hazard got icode=%h lu=%0d mp=%0d exp 1 0 0", E_icode, lu_cnt, mp_cnt);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 40; i++) begin
            set_d(4'h5, 4'h3, 4'h3, 4'h3);
            tick();
        end
        checks++;
        if (lu_cnt !== 4'hF || m_lu !== SAT) begin
            errors++; $display("FAIL sat_hold got lu=%0d exp 15", lu_cnt);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (lu_cnt !== '0) begin
            errors++; $display("FAIL sat_clear got lu=%0d exp 0", lu_cnt);
        end
    endtask

    task automatic test_random();
        logic [3:0] pick [8] = '{4'h1, 4'h2, 4'h5, 4'h6, 4'h7, 4'h9, 4'hB, 4'h3};
        logic [2:0] ctl;
        for (int i = 0; i < 300; i++) begin
            rst     = ($urandom_range(0, 29) == 0);
            e_Cnd   = $urandom_range(0, 1);
            M_icode = ($urandom_range(0, 7) == 0) ? 4'h9 : 4'h1;
            set_d(pick[$urandom_range(0, 7)],
                  ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 3)),
                  ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 3)),
                  ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 3)));
            d_ifun = 4'($urandom_range(0, 6));
            d_dstE = 4'($urandom_range(0, 15));
            #1;
            ctl = mdl_ctl();
            checks++;
            if ({F_stall, D_stall, D_bubble} !== ctl) begin
                errors++; $display("FAIL rand_ctl %0d got %b exp %b", i, {F_stall, D_stall, D_bubble}, ctl);
            end
            tick();
            checks++;
            if (dut_e !== m || int'(lu_cnt) !== m_lu || int'(mp_cnt) !== m_mp) begin
                errors++; $display("FAIL rand_state %0d got icode=%h lu=%0d mp=%0d exp icode=%h lu=%0d mp=%0d",
                                   i, E_icode, lu_cnt, mp_cnt, m.icode, m_lu, m_mp);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        m = NOPREG; m_lu = 0; m_mp = 0;
        test_reset();
        test_passthrough();
        test_load_use();
        test_rnone();
        test_mispredict();
        test_ret();
        test_reset_mid_hazard();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
